// File: rtl/cmp_sort_pkg.sv
// rtl/cmp_sort_pkg.sv - shared types and constants for the sorting controller
package cmp_sort_pkg;

    localparam int DATA_W = 8;
    localparam logic [7:0] SWAPS_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/cmp_sort_ctrl_cmp.sv
// rtl/cmp_sort_ctrl_cmp.sv - 8-bit unsigned magnitude comparator
module MagnitudeComparator_8b (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       eq,
    output logic       lt,
    output logic       gt
);

    assign eq = (a == b);
    assign lt = (a < b);
    assign gt = (a > b);

endmodule

// File: rtl/cmp_sort_ctrl.sv
// rtl/cmp_sort_ctrl.sv - bubble-sort controller sharing one comparator over a byte register file
module cmp_sort_ctrl
    import cmp_sort_pkg::*;
#(
    parameter int N          = 8,
    parameter bit DESCENDING = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [7:0]        swaps
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_PAIR_LAST = IDX_W'(N - 2);

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] mem [N];

    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] pair_idx;
    logic [IDX_W-1:0] pass_cnt;
    logic             pass_swapped;

    logic [DATA_W-1:0] cmp_a;
    logic [DATA_W-1:0] cmp_b;
    logic              cmp_eq;
    logic              cmp_lt;
    logic              cmp_gt;

    logic do_swap;
    logic pass_end;
    logic sort_done;
    logic in_fire;
    logic out_fire;

    assign cmp_a = mem[pair_idx];
    assign cmp_b = mem[pair_idx + 1'b1];

    MagnitudeComparator_8b u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .eq (cmp_eq),
        .lt (cmp_lt),
        .gt (cmp_gt)
    );

    // Equal pairs never swap, which keeps the sort stable.
    assign do_swap   = !cmp_eq && (DESCENDING ? cmp_lt : cmp_gt);
    assign pass_end  = (pair_idx == IDX_PAIR_LAST);
    // Finish on a clean pass (counting this cycle's compare) or after N-1 passes.
    assign sort_done = pass_end && (!(pass_swapped || do_swap) || (pass_cnt == IDX_PAIR_LAST));

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Gated so the port reads zero whenever nothing is being offered.
    assign out_data = out_valid ? mem[rd_idx] : '0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD: begin
                if (in_fire && (wr_idx == IDX_LAST)) begin
                    state_next = ST_SORT;
                end
            end
            ST_SORT: begin
                if (sort_done) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_fire && (rd_idx == IDX_LAST)) begin
                    state_next = ST_LOAD;
                end
            end
            default: state_next = ST_LOAD;
        endcase
    end

    // Register file: loads in LOAD, in-place exchange in SORT.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem[wr_idx] <= in_data;
        end else if ((state == ST_SORT) && do_swap) begin
            mem[pair_idx]        <= cmp_b;
            mem[pair_idx + 1'b1] <= cmp_a;
        end
    end

    // Indices, pass bookkeeping, swap counter and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx       <= '0;
            rd_idx       <= '0;
            pair_idx     <= '0;
            pass_cnt     <= '0;
            pass_swapped <= 1'b0;
            swaps        <= '0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            in_ready  <= (state_next == ST_LOAD);
            out_valid <= (state_next == ST_DRAIN);
            busy      <= (state_next != ST_LOAD);
            case (state)
                ST_LOAD: begin
                    if (in_fire) begin
                        wr_idx <= (wr_idx == IDX_LAST) ? '0 : wr_idx + 1'b1;
                    end
                    if (state_next == ST_SORT) begin
                        swaps        <= '0;
                        pair_idx     <= '0;
                        pass_cnt     <= '0;
                        pass_swapped <= 1'b0;
                    end
                end
                ST_SORT: begin
                    if (do_swap && (swaps != SWAPS_MAX)) begin
                        swaps <= swaps + 8'd1;
                    end
                    if (pass_end) begin
                        pair_idx     <= '0;
                        pass_swapped <= 1'b0;
                        pass_cnt     <= pass_cnt + 1'b1;
                    end else begin
                        pair_idx <= pair_idx + 1'b1;
                        if (do_swap) begin
                            pass_swapped <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_fire) begin
                        rd_idx <= (rd_idx == IDX_LAST) ? '0 : rd_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// tb/tb_cmp_sort_ctrl.sv - self-checking bench for cmp_sort_ctrl (ascending and descending instances)
module tb_cmp_sort_ctrl;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       in_ready_w  [2];
    logic       out_valid_w [2];
    logic [7:0] out_data_w  [2];
    logic       busy_w      [2];
    logic [7:0] swaps_w     [2];

    int vectors = 0;
    int miscompares = 0;

    // model: phase 0=load 1=sort 2=drain
    int         ph        [2];
    int         mcnt      [2];
    int         sort_left [2];
    int         exp_sw    [2];
    int         pend_sw   [2];
    int         sortcyc   [2];
    logic [7:0] ld        [2][N];
    logic [7:0] exp_out   [2][N];
    logic [7:0] prev_data [2];
    bit         prev_stall[2];
    logic [7:0] got0[$];
    logic [7:0] got1[$];

    always #5 clk = ~clk;

    cmp_sort_ctrl #(.N(N), .DESCENDING(1'b0)) dut_asc (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w[0]),
        .in_data   (in_data),
        .out_valid (out_valid_w[0]),
        .out_ready (out_ready),
        .out_data  (out_data_w[0]),
        .busy      (busy_w[0]),
        .swaps     (swaps_w[0])
    );

    cmp_sort_ctrl #(.N(N), .DESCENDING(1'b1)) dut_desc (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w[1]),
        .in_data   (in_data),
        .out_valid (out_valid_w[1]),
        .out_ready (out_ready),
        .out_data  (out_data_w[1]),
        .busy      (busy_w[1]),
        .swaps     (swaps_w[1])
    );

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, d, act, exp, $time);
        end
    endtask

    // Expected order, swap count (= strict inversions) and sort length from the loaded burst.
    function automatic void build_model(int d);
        logic [7:0] q[$];
        int inv = 0;
        int pmax = 0;
        int k;
        int passes;
        for (int i = 0; i < N; i++) q.push_back(ld[d][i]);
        if (d == 0) q.sort(); else q.rsort();
        for (int i = 0; i < N; i++) exp_out[d][i] = q[i];
        for (int j = 0; j < N; j++) begin
            k = 0;
            for (int i = 0; i < j; i++) begin
                if ((d == 0) ? (ld[d][i] > ld[d][j]) : (ld[d][i] < ld[d][j])) begin
                    k++;
                    inv++;
                end
            end
            if (k > pmax) pmax = k;
        end
        pend_sw[d] = (inv > 255) ? 255 : inv;
        passes = (pmax + 1 > N - 1) ? N - 1 : pmax + 1;
        sort_left[d] = (N - 1) * passes;
    endfunction

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                chk("rst_in_ready", d, in_ready_w[d], 1);
                chk("rst_out_valid", d, out_valid_w[d], 0);
                chk("rst_busy", d, busy_w[d], 0);
                chk("rst_swaps", d, swaps_w[d], 0);
                chk("rst_out_data", d, out_data_w[d], 0);
                ph[d] = 0;
                mcnt[d] = 0;
                exp_sw[d] = 0;
                prev_stall[d] = 0;
            end else begin
                chk("in_ready", d, in_ready_w[d], (ph[d] == 0));
                chk("out_valid", d, out_valid_w[d], (ph[d] == 2));
                chk("busy", d, busy_w[d], (ph[d] != 0));
                if (ph[d] != 1) chk("swaps", d, swaps_w[d], exp_sw[d]);
                if (ph[d] == 2) begin
                    chk("out_data", d, out_data_w[d], exp_out[d][mcnt[d]]);
                    if (prev_stall[d]) chk("stall_hold", d, out_data_w[d], prev_data[d]);
                    prev_data[d] = out_data_w[d];
                    prev_stall[d] = !out_ready;
                end else begin
                    prev_stall[d] = 0;
                end
                if (busy_w[d] && !out_valid_w[d]) sortcyc[d]++;
                case (ph[d])
                    0: if (in_valid) begin
                        ld[d][mcnt[d]] = in_data;
                        mcnt[d]++;
                        if (mcnt[d] == N) begin
                            build_model(d);
                            ph[d] = 1;
                            mcnt[d] = 0;
                            exp_sw[d] = 0;
                        end
                    end
                    1: begin
                        sort_left[d]--;
                        if (sort_left[d] == 0) begin
                            ph[d] = 2;
                            exp_sw[d] = pend_sw[d];
                        end
                    end
                    default: if (out_ready) begin
                        if (d == 0) got0.push_back(out_data_w[d]); else got1.push_back(out_data_w[d]);
                        mcnt[d]++;
                        if (mcnt[d] == N) begin
                            ph[d] = 0;
                            mcnt[d] = 0;
                        end
                    end
                endcase
            end
        end
    end

    function automatic bit both_idle();
        return in_ready_w[0] && in_ready_w[1] && !out_valid_w[0] && !out_valid_w[1];
    endfunction

    task automatic wait_idle();
        int t = 0;
        while (!both_idle() && t < 600) begin
            @(posedge clk); #1;
            t++;
        end
        vectors++;
        if (t >= 600) begin
            miscompares++;
            $display("FAIL idle_timeout: waited %0d cycles, limit 600", t);
        end
    endtask

    task automatic load_burst(input logic [7:0] v[N], input bit gaps);
        int g;
        for (int k = 0; k < N; k++) begin
            g = gaps ? $urandom_range(0, 3) : 0;
            repeat (g) begin
                in_valid = 1'b0;
                in_data = 8'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data = v[k];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit stall);
        int t = 0;
        bit stalled = 0;
        out_ready = 1'b1;
        while (!both_idle() && t < 600) begin
            if (stall && !stalled && got0.size() == 3) begin
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
                stalled = 1;
            end
            @(posedge clk); #1;
            t++;
        end
        vectors++;
        if (t >= 600) begin
            miscompares++;
            $display("FAIL drain_timeout: waited %0d cycles, limit 600", t);
        end
        out_ready = 1'b0;
    endtask

    task automatic run_burst(input logic [7:0] v[N], input bit gaps, input bit stall, input bit lit,
                             input logic [7:0] ea[N], input logic [7:0] ed[N],
                             input int cyc_a, input int sw_a, input int cyc_d, input int sw_d);
        wait_idle();
        got0.delete();
        got1.delete();
        sortcyc[0] = 0;
        sortcyc[1] = 0;
        load_burst(v, gaps);
        drain(stall);
        chk("count_out", 0, got0.size(), N);
        chk("count_out", 1, got1.size(), N);
        if (lit && got0.size() == N && got1.size() == N) begin
            for (int k = 0; k < N; k++) begin
                chk("lit_out", 0, got0[k], ea[k]);
                chk("lit_out", 1, got1[k], ed[k]);
            end
        end
        if (cyc_a >= 0) chk("lit_sort_cycles", 0, sortcyc[0], cyc_a);
        if (cyc_d >= 0) chk("lit_sort_cycles", 1, sortcyc[1], cyc_d);
        if (sw_a >= 0) chk("lit_swaps", 0, swaps_w[0], sw_a);
        if (sw_d >= 0) chk("lit_swaps", 1, swaps_w[1], sw_d);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("async_rst_in_ready", d, in_ready_w[d], 1);
            chk("async_rst_out_valid", d, out_valid_w[d], 0);
            chk("async_rst_swaps", d, swaps_w[d], 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    logic [7:0] v_mix [N], e_mix_a [N], e_mix_d [N];
    logic [7:0] v_up  [N], v_down  [N];
    logic [7:0] v_dup [N], e_dup_a [N], e_dup_d [N];
    logic [7:0] v_rnd [N];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        v_mix   = '{8'd7, 8'd3, 8'd250, 8'd0, 8'd3, 8'd128, 8'd1, 8'd64};
        e_mix_a = '{8'd0, 8'd1, 8'd3, 8'd3, 8'd7, 8'd64, 8'd128, 8'd250};
        e_mix_d = '{8'd250, 8'd128, 8'd64, 8'd7, 8'd3, 8'd3, 8'd1, 8'd0};
        v_up    = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        v_down  = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        v_dup   = '{8'd242, 8'd246, 8'd10, 8'd10, 8'd14, 8'd246, 8'd0, 8'd255};
        e_dup_a = '{8'd0, 8'd10, 8'd10, 8'd14, 8'd242, 8'd246, 8'd246, 8'd255};
        e_dup_d = '{8'd255, 8'd246, 8'd246, 8'd242, 8'd14, 8'd10, 8'd10, 8'd0};
        for (int k = 0; k < N; k++) v_rnd[k] = 8'($urandom);

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 8'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // mixed values: 14 inversions ascending, 13 descending, 6 passes ascending
        run_burst(v_mix, 0, 0, 1, e_mix_a, e_mix_d, 42, 14, -1, 13);
        // already sorted / reverse sorted
        run_burst(v_up, 0, 0, 1, v_up, v_down, 7, 0, 49, 28);
        run_burst(v_down, 0, 0, 1, v_up, v_down, 49, 28, 7, 0);
        // duplicates: swap counts equal strict inversions only
        run_burst(v_dup, 0, 0, 1, e_dup_a, e_dup_d, -1, 12, -1, 14);
        // input gaps and output stall
        run_burst(v_rnd, 1, 1, 0, v_rnd, v_rnd, -1, -1, -1, -1);

        // reset during SORT
        wait_idle();
        load_burst(v_down, 0);
        repeat (10) @(posedge clk);
        #1;
        pulse_reset();

        // reset during DRAIN after 3 outputs
        wait_idle();
        got0.delete();
        got1.delete();
        load_burst(v_rnd, 0);
        begin
            int t = 0;
            out_ready = 1'b1;
            while (got0.size() < 3 && t < 600) begin
                @(posedge clk); #1;
                t++;
            end
            vectors++;
            if (t >= 600) begin
                miscompares++;
                $display("FAIL drain3_timeout: waited %0d cycles, limit 600", t);
            end
        end
        pulse_reset();

        // full burst after reset sorts correctly
        run_burst(v_mix, 0, 0, 1, e_mix_a, e_mix_d, 42, 14, -1, 13);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cmp_sort_ctrl.md
# cmp_sort_ctrl

Sequential sorting controller built around a single shared 8-bit magnitude comparator. It accepts a burst of N unsigned bytes over a valid/ready stream and sorts them in place with bubble-sort passes, one comparison per cycle. It then streams the sorted bytes out over a second valid/ready port. It is the sequencing layer that time-multiplexes the comparator over a small register file.

## Interface
- N, default 8: elements per burst; legal range 2..16.
- DESCENDING, default 0: 0 sorts ascending (smallest first out), 1 sorts descending.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input byte valid.
- in_ready  out  1  controller accepts input; high only in LOAD.
- in_data  in  8  unsigned input byte.
- out_valid  out  1  sorted byte valid; high only in DRAIN.
- out_ready  in  1  downstream accepts output.
- out_data  out  8  sorted byte.
- busy  out  1  high in SORT and DRAIN.
- swaps  out  8  swaps performed in the last sort, saturating at 255; held until the next SORT entry.

## Operation
- States: LOAD, SORT, DRAIN. Reset state is LOAD.
- A transfer occurs on any cycle where valid and ready are both high.
- LOAD:
  - in_ready=1.
  - Each input transfer writes mem[wr_idx] and increments wr_idx.
  - The Nth transfer moves the block to SORT and clears wr_idx.
- SORT:
  - A pair index i runs 0..N-2 per pass. Each cycle the comparator sees a=mem[i], b=mem[i+1].
  - Swap condition: gt when DESCENDING=0, lt when DESCENDING=1. eq never swaps, so the sort is stable.
  - A swap exchanges mem[i] and mem[i+1] in the same cycle, sets pass_swapped, and increments swaps (saturating).
  - End of pass, i=N-2:
    - If no swap occurred this pass, including on this cycle, or N-1 passes have completed, go to DRAIN.
    - Otherwise clear pass_swapped, set i=0, and start the next pass.
- DRAIN:
  - out_valid=1, out_data=mem[rd_idx].
  - Each output transfer increments rd_idx.
  - The Nth transfer returns to LOAD with rd_idx=0.
  - out_data holds stable while out_valid=1 and out_ready=0.
- swaps clears to 0 on entry to SORT.
- in_valid is ignored outside LOAD. out_ready is ignored outside DRAIN.
- Reset, including mid-SORT or mid-DRAIN:
  - Go to LOAD and clear all indices, pass counters and swaps.
  - in_ready=1 and out_valid=0 as soon as rst_n is low.
  - mem contents are don't-care.
  - A partially loaded or partially drained burst is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, busy=0, swaps=0.
- Registered outputs: in_ready, out_valid, busy, swaps. out_data is mem[rd_idx] through a mux.
- Load: N cycles minimum at full input rate.
- The cycle after the Nth input transfer is the first SORT cycle.
- SORT length: (N-1) × passes cycles, with passes in 1..N-1.
  - Already-sorted input: exactly N-1 cycles.
  - Worst case: (N-1)² cycles.
- out_valid rises the cycle after the final SORT cycle.
- Drain: N cycles minimum with out_ready held high.
- The cycle after the Nth output transfer, in_ready=1.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Structure
- Shared package cmp_sort_pkg holds:
  - the state enum (LOAD, SORT, DRAIN);
  - the 8-bit data width constant;
  - the swaps saturation limit constant.
- One sub-module: the team's existing MagnitudeComparator_8b, instantiated once with eq/lt/gt driving the swap decision.
- No other hierarchy. mem is a flop array of N×8.

## Test plan
- Ascending, N=8:
  - Stimulus: load 7,3,250,0,3,128,1,64.
  - Required output: 0,1,3,3,7,64,128,250; swaps nonzero; busy low after the last output transfer.
- Already sorted:
  - Stimulus: load 1..8.
  - Required: SORT lasts exactly 7 cycles, swaps=0, output 1..8.
- Reverse order worst case:
  - Stimulus: load 8..1.
  - Required: SORT lasts 49 cycles, swaps=28, output 1..8.
- DESCENDING=1 with duplicates:
  - Stimulus: load 242,246,10,10,14,246,0,255.
  - Required output: 255,246,246,242,14,10,10,0; equal pairs are never swapped.
- Backpressure:
  - Stimulus: toggle in_valid randomly during LOAD; hold out_ready=0 for 5 cycles mid-DRAIN.
  - Required: no data loss or duplication; out_data stable while stalled.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during SORT, then again during DRAIN after 3 outputs.
  - Required: immediate return to in_ready=1, out_valid=0, swaps=0; the next full burst sorts correctly.
